// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul result path.
// Element width follows the multiply operand width and the inner dimension.
package matmul_pkg;

   function automatic int acc_width(input int dw, input int m);
      return 2 * dw + $clog2(m);
   endfunction

   function automatic int idx_w(input int x);
      return (x > 1) ? $clog2(x) : 1;
   endfunction

   localparam int DATA_WIDTH_DEF = 16;
   localparam int M_DEF = 32;
   localparam int ACC_W_DEF = acc_width(DATA_WIDTH_DEF, M_DEF);

   typedef logic signed [ACC_W_DEF-1:0] mat_elem;

   typedef enum logic {
      IDLE,
      STREAM
   } stream_state_e;

endpackage

// File: rtl/matmul_result_streamer_if.sv
// Load and stream-out bundle of the result streamer.
// The slave modport is the streamer's view; master is the environment's.
interface matmul_result_streamer_if
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int M = 32,
   parameter int N = 32,
   parameter int Q = 32
);
   localparam int ACC_W = acc_width(DATA_WIDTH, M);
   localparam int RW = idx_w(N);
   localparam int CW = idx_w(Q);

   logic                    load_valid;
   logic                    load_ready;
   logic signed [ACC_W-1:0] mat_in [N][Q];
   logic signed [ACC_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [RW-1:0]           out_row;
   logic [CW-1:0]           out_col;
   logic                    out_last_row;
   logic                    out_last;
   logic                    busy;

   modport master (
      output load_valid, mat_in, out_ready,
      input  load_ready, out_data, out_valid, out_row,
      input  out_col, out_last_row, out_last, busy
   );

   modport slave (
      input  load_valid, mat_in, out_ready,
      output load_ready, out_data, out_valid, out_row,
      output out_col, out_last_row, out_last, busy
   );

endinterface

// File: rtl/matmul_result_streamer_index_counter.sv
// Row-major row/column walker with registered end-of-row/end-of-matrix
// flags; also exposes the following position for look-ahead reads.
module matrix_index_counter
   import matmul_pkg::*;
#(
   parameter int N = 32,
   parameter int Q = 32,
   localparam int RW = idx_w(N),
   localparam int CW = idx_w(Q)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          advance,
   input  logic          stop,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last_row,
   output logic          last,
   output logic [RW-1:0] nxt_row,
   output logic [CW-1:0] nxt_col
);
   localparam logic [RW-1:0] ROW_MAX = RW'(N - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(Q - 1);

   always_comb begin
      nxt_row = row;
      nxt_col = col + 1'b1;
      if (col == COL_MAX) begin
         nxt_col = '0;
         nxt_row = (row == ROW_MAX) ? '0 : row + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || stop) begin
         row      <= '0;
         col      <= '0;
         last_row <= 1'b0;
         last     <= 1'b0;
      end else if (start) begin
         row      <= '0;
         col      <= '0;
         last_row <= (Q == 1);
         last     <= (N == 1) && (Q == 1);
      end else if (advance) begin
         row      <= nxt_row;
         col      <= nxt_col;
         last_row <= (nxt_col == COL_MAX);
         last     <= (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);
      end
   end

endmodule

// File: rtl/matmul_result_streamer.sv
// Captures a whole result matrix in one edge and replays it row-major,
// one element per valid/ready beat, with indices and row/matrix markers.
module matmul_result_streamer
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int M = 32,
   parameter int N = 32,
   parameter int Q = 32
) (
   input logic clk,
   input logic reset,
   matmul_result_streamer_if.slave bus
);
   localparam int ACC_W = acc_width(DATA_WIDTH, M);
   localparam int RW = idx_w(N);
   localparam int CW = idx_w(Q);

   stream_state_e           state;
   logic signed [ACC_W-1:0] held [N][Q];
   logic [RW-1:0]           nxt_row;
   logic [CW-1:0]           nxt_col;
   logic                    last_row;
   logic                    last;
   logic                    start;
   logic                    hs;
   logic                    advance;
   logic                    stop;

   assign start   = (state == IDLE) && bus.load_valid;
   assign hs      = (state == STREAM) && bus.out_ready;
   assign advance = hs && !last;
   assign stop    = hs && last;

   assign bus.load_ready   = (state == IDLE) && !reset;
   assign bus.out_last_row = last_row;
   assign bus.out_last     = last;

   matrix_index_counter #(
      .N(N),
      .Q(Q)
   ) u_idx (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .advance  (advance),
      .stop     (stop),
      .row      (bus.out_row),
      .col      (bus.out_col),
      .last_row (last_row),
      .last     (last),
      .nxt_row  (nxt_row),
      .nxt_col  (nxt_col)
   );

   // Bulk storage needs no reset; it is only read after a capture.
   always_ff @(posedge clk) begin
      if (start && !reset) held <= bus.mat_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.load_valid) begin
                  state         <= STREAM;
                  bus.out_valid <= 1'b1;
                  bus.busy      <= 1'b1;
                  bus.out_data  <= bus.mat_in[0][0];
               end
            end
            STREAM: begin
               if (bus.out_ready) begin
                  if (last) begin
                     state         <= IDLE;
                     bus.out_valid <= 1'b0;
                     bus.busy      <= 1'b0;
                  end else begin
                     bus.out_data <= held[nxt_row][nxt_col];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Randomized bench: a queue of expected beats is built from each accepted
// matrix and drained on every handshake, then compared against the DUT.
module tb_matmul_result_streamer;
   import matmul_pkg::*;

   localparam int DW = 16;
   localparam int MM = 32;
   localparam int N = 2;
   localparam int Q = 3;
   localparam int ACC_W = acc_width(DW, MM);

   typedef struct {
      logic signed [ACC_W-1:0] d;
      int r;
      int c;
      bit lr;
      bit l;
   } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   bit was_rst = 1'b1;
   beat_t exp_q[$];
   logic signed [ACC_W-1:0] mat_v [N][Q];

   always #5 clk = ~clk;

   matmul_result_streamer_if #(.DATA_WIDTH(DW), .M(MM), .N(N), .Q(Q)) b ();
   matmul_result_streamer_if #(.DATA_WIDTH(DW), .M(MM), .N(1), .Q(1)) d ();

   matmul_result_streamer #(.DATA_WIDTH(DW), .M(MM), .N(N), .Q(Q)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b.slave)
   );

   matmul_result_streamer #(.DATA_WIDTH(DW), .M(MM), .N(1), .Q(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (d.slave)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic logic signed [ACC_W-1:0] rnd_elem();
      logic [63:0] v;
      v = {$urandom(), $urandom()};
      return ACC_W'(v);
   endfunction

   task automatic check_outputs();
      bit empty;
      empty = (exp_q.size() == 0);
      chk("load_ready", b.load_ready, 64'(empty && !reset));
      chk("busy", b.busy, 64'(!empty));
      chk("out_valid", b.out_valid, 64'(!empty));
      if (!empty) begin
         chk("out_data", b.out_data, exp_q[0].d);
         chk("out_row", b.out_row, exp_q[0].r);
         chk("out_col", b.out_col, exp_q[0].c);
         chk("out_last_row", b.out_last_row, exp_q[0].lr);
         chk("out_last", b.out_last, exp_q[0].l);
      end else begin
         chk("idle_last_row", b.out_last_row, 0);
         chk("idle_last", b.out_last, 0);
         if (was_rst) begin
            chk("rst_data", b.out_data, 0);
            chk("rst_row", b.out_row, 0);
            chk("rst_col", b.out_col, 0);
         end
      end
   endtask

   // One clock: check what the last edge produced, then drive the next.
   task automatic cycle(input bit rdy, input bit ld, input bit rst);
      beat_t bt;
      @(negedge clk);
      check_outputs();
      b.out_ready = rdy;
      b.load_valid = ld;
      reset = rst;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < Q; c++) b.mat_in[r][c] = mat_v[r][c];
      if (rst) begin
         exp_q.delete();
      end else if (exp_q.size() > 0) begin
         if (rdy) void'(exp_q.pop_front());
      end else if (ld) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < Q; c++) begin
               bt.d = mat_v[r][c];
               bt.r = r;
               bt.c = c;
               bt.lr = (c == Q - 1);
               bt.l = (r == N - 1) && (c == Q - 1);
               exp_q.push_back(bt);
            end
      end
      was_rst = rst;
      @(posedge clk);
   endtask

   task automatic fill_seq();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < Q; c++) mat_v[r][c] = ACC_W'(r * Q + c + 1);
   endtask

   task automatic fill_rnd();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < Q; c++) mat_v[r][c] = rnd_elem();
   endtask

   task automatic drain(input int pct);
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         cycle($urandom_range(0, 99) < pct, 1'b0, 1'b0);
         guard++;
      end
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      b.load_valid = 1'b0;
      b.out_ready = 1'b0;
      d.load_valid = 1'b0;
      d.out_ready = 1'b0;
      d.mat_in[0][0] = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < Q; c++) mat_v[r][c] = '0;

      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);

      fill_seq();
      cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);

      fill_seq();
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 20; k++) cycle((k % 3) == 0, 1'b0, 1'b0);
      drain(100);

      fill_rnd();
      mat_v[0][0] = -ACC_W'(5);
      mat_v[0][1] = ACC_W'(-(64'sd1 <<< 35));
      mat_v[0][2] = ACC_W'((64'sd1 <<< 35) - 1);
      cycle(1'b0, 1'b1, 1'b0);
      drain(60);

      fill_seq();
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      fill_rnd();
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      while (exp_q.size() > 1) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      fill_rnd();
      cycle(1'b0, 1'b1, 1'b0);
      drain(70);

      fill_seq();
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      fill_rnd();
      cycle(1'b1, 1'b1, 1'b0);
      drain(100);

      for (int i = 0; i < 200; i++) begin
         fill_rnd();
         cycle($urandom_range(0, 99) < 70, $urandom_range(0, 3) == 0, 1'b0);
      end
      drain(100);

      @(negedge clk);
      d.mat_in[0][0] = ACC_W'(42);
      d.load_valid = 1'b1;
      d.out_ready = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         d.load_valid = 1'b0;
         d.mat_in[0][0] = ACC_W'(7);
         chk("n1_valid", d.out_valid, 1);
         chk("n1_data", d.out_data, 42);
         chk("n1_last_row", d.out_last_row, 1);
         chk("n1_last", d.out_last, 1);
         chk("n1_busy", d.busy, 1);
         chk("n1_load_ready", d.load_ready, 0);
         d.out_ready = (i == 1);
         @(posedge clk);
      end
      @(negedge clk);
      d.out_ready = 1'b0;
      chk("n1_idle_valid", d.out_valid, 0);
      chk("n1_idle_busy", d.busy, 0);
      chk("n1_idle_last", d.out_last, 0);
      chk("n1_idle_ready", d.load_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
